// File: rtl/sevenseg_pkg.sv
// Shared definitions for the SPI seven-segment mux: command codes, frame layout,
// digit register type and the hex-to-segment map.
package sevenseg_pkg;

  localparam int FRAME_W = 8;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_DP  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_CLR = 2'b11;

  localparam int FR_CMD_MSB = 7;
  localparam int FR_CMD_LSB = 6;
  localparam int FR_IDX_MSB = 5;
  localparam int FR_IDX_LSB = 4;
  localparam int FR_NIB_MSB = 3;
  localparam int FR_NIB_LSB = 0;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] nib;
  } digit_t;

  localparam digit_t DIGIT_RST = '{blank: 1'b1, dp: 1'b0, nib: 4'h0};

  // Segment a is bit 0, g is bit 6.
  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    case (n)
      4'h0:    hex7seg = 7'b0111111;
      4'h1:    hex7seg = 7'b0000110;
      4'h2:    hex7seg = 7'b1011011;
      4'h3:    hex7seg = 7'b1001111;
      4'h4:    hex7seg = 7'b1100110;
      4'h5:    hex7seg = 7'b1101101;
      4'h6:    hex7seg = 7'b1111101;
      4'h7:    hex7seg = 7'b0000111;
      4'h8:    hex7seg = 7'b1111111;
      4'h9:    hex7seg = 7'b1101111;
      4'hA:    hex7seg = 7'b1110111;
      4'hB:    hex7seg = 7'b1111100;
      4'hC:    hex7seg = 7'b0111001;
      4'hD:    hex7seg = 7'b1011110;
      4'hE:    hex7seg = 7'b1111001;
      default: hex7seg = 7'b1110001;
    endcase
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// Oversampled SPI mode-0 receiver producing 8-bit frames and abort pulses.
// Latency: frame_valid 3 clk after the 8th sclk rise at the pins.
// Backpressure: none; frames are presented for one cycle and must be taken.
module spi_frame_rx
  import sevenseg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_sclk,
  input  logic               spi_mosi,
  input  logic               spi_ss_n,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame,
  output logic               abort
);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;
  logic ss_s1, ss_s2, ss_s3;
  logic [FRAME_W-1:0] sr;
  logic [2:0]         cnt;

  // ss_n syncs reset high so leaving reset never looks like a deselect edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1     <= 1'b0;
      sclk_s2     <= 1'b0;
      sclk_s3     <= 1'b0;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      ss_s1       <= 1'b1;
      ss_s2       <= 1'b1;
      ss_s3       <= 1'b1;
      sr          <= '0;
      cnt         <= '0;
      frame_valid <= 1'b0;
      frame       <= '0;
      abort       <= 1'b0;
    end else begin
      sclk_s1     <= spi_sclk;
      sclk_s2     <= sclk_s1;
      sclk_s3     <= sclk_s2;
      mosi_s1     <= spi_mosi;
      mosi_s2     <= mosi_s1;
      ss_s1       <= spi_ss_n;
      ss_s2       <= ss_s1;
      ss_s3       <= ss_s2;
      frame_valid <= 1'b0;
      abort       <= 1'b0;
      if (ss_s2) begin
        cnt <= '0;
        if (!ss_s3 && (cnt != 3'd0)) abort <= 1'b1;
      end else if (sclk_s2 && !sclk_s3) begin
        sr  <= {sr[FRAME_W-2:0], mosi_s2};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          frame_valid <= 1'b1;
          frame       <= {sr[FRAME_W-2:0], mosi_s2};
        end
      end
    end
  end

endmodule

// File: rtl/spi_sevenseg_mux.sv
// SPI-addressed digit registers driving a time-multiplexed seven-segment display.
// Latency: register write 1 clk after frame_valid; seg follows 1 clk after that.
// Backpressure: none; every received frame is accepted or flagged as an error.
module spi_sevenseg_mux
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_ss_n,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int   IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   PW  = $clog2(REFRESH_DIV);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic               frame_valid;
  logic               abort;
  logic [FRAME_W-1:0] frame;

  spi_frame_rx u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_ss_n    (spi_ss_n),
    .frame_valid (frame_valid),
    .frame       (frame),
    .abort       (abort)
  );

  logic [1:0] cmd;
  logic [1:0] idx;
  logic [3:0] nib;
  logic       is_wr;
  logic       idx_ok;

  assign cmd    = frame[FR_CMD_MSB:FR_CMD_LSB];
  assign idx    = frame[FR_IDX_MSB:FR_IDX_LSB];
  assign nib    = frame[FR_NIB_MSB:FR_NIB_LSB];
  assign is_wr  = (cmd == CMD_WR) || (cmd == CMD_DP);
  assign idx_ok = ({1'b0, idx} < 3'(NUM_DIGITS));

  digit_t dig_q [NUM_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= DIGIT_RST;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= frame_valid && (!is_wr || idx_ok);
      frame_err  <= abort || (frame_valid && is_wr && !idx_ok);
      if (frame_valid) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (cmd == CMD_CLR)
            dig_q[i] <= DIGIT_RST;
          else if (is_wr && (idx == 2'(i)))
            dig_q[i] <= '{blank: 1'b0, dp: (cmd == CMD_DP), nib: nib};
        end
      end
    end
  end

  logic [PW-1:0] presc;
  logic [IW-1:0] scan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      scan_q <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      if (scan_q == IW'(NUM_DIGITS - 1)) scan_q <= '0;
      else                               scan_q <= scan_q + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  digit_t                cur;
  logic [NUM_DIGITS-1:0] en_raw;
  logic [7:0]            seg_raw;

  // Outputs are built from the already-updated digit and scan registers.
  always_comb begin
    cur    = dig_q[0];
    en_raw = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == IW'(i)) begin
        cur       = dig_q[i];
        en_raw[i] = 1'b1;
      end
    end
    seg_raw = {cur.dp, cur.blank ? 7'h00 : hex7seg(cur.nib)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= {8{INV}};
      dig_en <= {NUM_DIGITS{INV}};
    end else begin
      seg    <= seg_raw ^ {8{INV}};
      dig_en <= en_raw ^ {NUM_DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_spi_sevenseg_mux.sv
// Directed bench: a 4-digit active-high and a 2-digit active-low instance share
// the SPI pins; vectors list frames with the expected pulses and digit contents.
module tb_spi_sevenseg_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, spi_sclk, spi_mosi, spi_ss_n;
  logic [7:0] seg_a, seg_b;
  logic [3:0] dig_en_a;
  logic [1:0] dig_en_b;
  logic       done_a, err_a, done_b, err_b;

  spi_sevenseg_mux #(.NUM_DIGITS(4), .REFRESH_DIV(8), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_ss_n(spi_ss_n), .seg(seg_a), .dig_en(dig_en_a),
    .frame_done(done_a), .frame_err(err_a)
  );

  spi_sevenseg_mux #(.NUM_DIGITS(2), .REFRESH_DIV(8), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_ss_n(spi_ss_n), .seg(seg_b), .dig_en(dig_en_b),
    .frame_done(done_b), .frame_err(err_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_done_a = 0, n_err_a = 0, n_done_b = 0, n_err_b = 0;
  int t_done_prev = 0, t_done_last = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done_a) begin
      n_done_a++;
      t_done_prev = t_done_last;
      t_done_last = cyc;
    end
    if (err_a)  n_err_a++;
    if (done_b) n_done_b++;
    if (err_b)  n_err_b++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    repeat (2) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (2) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] f, input int n);
    for (int i = 0; i < n; i++) spi_bit(f[7-i]);
  endtask

  task automatic send(input logic [7:0] f, input int n);
    @(negedge clk);
    spi_ss_n = 1'b0;
    repeat (2) @(negedge clk);
    spi_bits(f, n);
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_a(input int d, input logic [7:0] exp, input string name);
    logic [3:0] want;
    int k;
    want = 4'(1 << d);
    k = 0;
    while (dig_en_a !== want && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (dig_en_a !== want) begin
      checks++;
      failures++;
      $display("FAIL %s: dig_en_a stuck at %0h waiting for %0h", name, dig_en_a, want);
    end else begin
      chk(name, {24'b0, seg_a}, {24'b0, exp});
    end
  endtask

  task automatic check_b(input int d, input logic [7:0] exp, input string name);
    logic [1:0] want;
    int k;
    want = ~(2'(1 << d));
    k = 0;
    while (dig_en_b !== want && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (dig_en_b !== want) begin
      checks++;
      failures++;
      $display("FAIL %s: dig_en_b stuck at %0h waiting for %0h", name, dig_en_b, want);
    end else begin
      chk(name, {24'b0, seg_b}, {24'b0, exp});
    end
  endtask

  typedef struct {
    logic [7:0] f;
    int         nbits;
    int         da, ea, db, eb;
    int         adig;
    logic [7:0] aseg;
    int         bdig;
    logic [7:0] bseg;
    string      name;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int         k;
    int         b_da, b_ea, b_db, b_eb;
    logic [3:0] old;
    logic [3:0] exp_walk [4];
    logic [1:0] exp_walk_b [4];

    // nbits 0 means only inspect the display; adig/bdig -1 skips that instance.
    vecs[0] = '{8'b10_01_0101, 8, 1, 0, 1, 0,  1, 8'h6D,  1, 8'h92, "wr_d1_5"};
    vecs[1] = '{8'h00,         0, 0, 0, 0, 0,  0, 8'h00,  0, 8'hFF, "others_blank"};
    vecs[2] = '{8'h00,         0, 0, 0, 0, 0,  2, 8'h00, -1, 8'h00, "d2_blank"};
    vecs[3] = '{8'b01_11_1010, 8, 1, 0, 0, 1,  3, 8'hF7,  1, 8'h92, "dp_d3_A"};
    vecs[4] = '{8'b11_00_0000, 8, 1, 0, 1, 0,  1, 8'h00,  1, 8'hFF, "clr"};
    vecs[5] = '{8'h00,         0, 0, 0, 0, 0,  3, 8'h00, -1, 8'h00, "clr_d3"};
    vecs[6] = '{8'b10_00_0101, 5, 0, 1, 0, 1,  0, 8'h00,  0, 8'hFF, "abort5"};
    vecs[7] = '{8'b10_00_0000, 8, 1, 0, 1, 0,  0, 8'h3F,  0, 8'hC0, "wr_d0_0"};
    vecs[8] = '{8'b10_11_0001, 8, 1, 0, 0, 1,  3, 8'h06,  1, 8'hFF, "wr_idx3"};
    vecs[9] = '{8'h00,         0, 0, 0, 0, 0,  1, 8'h00,  0, 8'hC0, "b_d0_kept"};

    exp_walk[0] = 4'b0010; exp_walk[1] = 4'b0100; exp_walk[2] = 4'b1000; exp_walk[3] = 4'b0001;
    exp_walk_b[0] = 2'b01; exp_walk_b[1] = 2'b10; exp_walk_b[2] = 2'b01; exp_walk_b[3] = 2'b10;

    rst_n    = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_ss_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg_a",    {24'b0, seg_a}, 32'h00);
    chk("rst_dig_en_a", {28'b0, dig_en_a}, 32'h0);
    chk("rst_done_a",   {31'b0, done_a}, 32'h0);
    chk("rst_err_a",    {31'b0, err_a}, 32'h0);
    chk("rst_seg_b",    {24'b0, seg_b}, 32'hFF);
    chk("rst_dig_en_b", {30'b0, dig_en_b}, 32'h3);

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_en_a", {28'b0, dig_en_a}, 32'h1);
    chk("first_en_b", {30'b0, dig_en_b}, 32'h2);
    chk("idle_seg_a", {24'b0, seg_a}, 32'h00);
    chk("idle_seg_b", {24'b0, seg_b}, 32'hFF);

    for (int i = 0; i < 4; i++) begin
      old = dig_en_a;
      k = 0;
      while (dig_en_a === old && k < 30) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("walk_en_%0d", i), {28'b0, dig_en_a}, {28'b0, exp_walk[i]});
      chk($sformatf("walk_gap_%0d", i), k, 8);
      chk($sformatf("walk_en_b_%0d", i), {30'b0, dig_en_b}, {30'b0, exp_walk_b[i]});
      chk($sformatf("walk_seg_%0d", i), {24'b0, seg_a}, 32'h00);
    end

    for (int v = 0; v < 10; v++) begin
      b_da = n_done_a; b_ea = n_err_a; b_db = n_done_b; b_eb = n_err_b;
      if (vecs[v].nbits > 0) send(vecs[v].f, vecs[v].nbits);
      chk({vecs[v].name, "_done_a"}, n_done_a - b_da, vecs[v].da);
      chk({vecs[v].name, "_err_a"},  n_err_a - b_ea,  vecs[v].ea);
      chk({vecs[v].name, "_done_b"}, n_done_b - b_db, vecs[v].db);
      chk({vecs[v].name, "_err_b"},  n_err_b - b_eb,  vecs[v].eb);
      if (vecs[v].adig >= 0) check_a(vecs[v].adig, vecs[v].aseg, {vecs[v].name, "_seg_a"});
      if (vecs[v].bdig >= 0) check_b(vecs[v].bdig, vecs[v].bseg, {vecs[v].name, "_seg_b"});
    end

    // Two frames in one select window, sclk at clk/4.
    b_da = n_done_a;
    @(negedge clk);
    spi_ss_n = 1'b0;
    repeat (2) @(negedge clk);
    spi_bits(8'b10_10_0011, 8);
    spi_bits(8'b10_00_1111, 8);
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("b2b_done_cnt", n_done_a - b_da, 2);
    chk("b2b_spacing", t_done_last - t_done_prev, 32);
    check_a(2, 8'h4F, "b2b_d2");
    check_a(0, 8'h71, "b2b_d0");

    // Reset in the middle of a frame drops it and blanks the display.
    b_ea = n_err_a; b_da = n_done_a;
    @(negedge clk);
    spi_ss_n = 1'b0;
    repeat (2) @(negedge clk);
    spi_bits(8'b10_01_1000, 4);
    rst_n    = 1'b0;
    spi_ss_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_err", n_err_a - b_ea, 0);
    chk("midrst_done", n_done_a - b_da, 0);
    check_a(0, 8'h00, "midrst_d0");
    check_a(2, 8'h00, "midrst_d2");
    check_b(0, 8'hFF, "midrst_b_d0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
